core_dbg_itr_ctrl: RTL and testbench
====================================

// Module: core_dbg_itr_ctrl
// PURPOSE
//  Debug-interface controller for the core: holds DBGSC/DRUNCTRL/ITR0-3/DTR registers (offsets 0-7).
//  Sequences halt, resume and ITR execution, and injects ITR0..ITR3 one at a time into the halted pipeline
//  over a valid/ready port. Shares the 64-bit DTR between the external debug port and the core.
//  Sits between the debug transport and the core front end (instruction-injection mux).
// PARAMETERS
//  INSN_WIDTH   32   width of one ITR / injected instruction
//  DTR_WIDTH    64   data transfer register width (split HI/LO 32-bit halves)
//  ITR_TIMEOUT  255  max cycles WAIT_RETIRE waits for itr_retire before error (>=1)
// PORTS
//  clk           in   1   core clock (single clock domain)
//  rst           in   1   synchronous reset, active-high
//  dbg_wr        in   1   debug register write strobe
//  dbg_rd        in   1   debug register read strobe
//  dbg_addr      in   4   register offset 0..7 (8..15 reserved)
//  dbg_wdata     in   32  write data
//  dbg_rdata     out  32  read data, valid 1 cycle after dbg_rd
//  dbg_busy      out  1   high in ISSUE/WAIT_RETIRE
//  halt_req      out  1   request core to halt
//  halted        in   1   core reports halted
//  resume_req    out  1   request core to resume
//  itr_valid     out  1   injected instruction valid
//  itr_ready     in   1   core accepts injected instruction
//  itr_insn      out  32  injected instruction (ITR[itr_idx])
//  itr_idx       out  2   index of the injected ITR
//  itr_retire    in   1   injected instruction retired
//  itr_error     in   1   injected instruction faulted
//  dtr_core_wr   in   1   core writes full DTR
//  dtr_core_wdata in  64  core DTR write data
//  dtr_core_rdata out 64  current DTR contents
// BEHAVIOUR
//  Reset: all registers, DTR, ITRs, err and idx = 0; state RUN; all outputs 0.
//  Reset mid-operation aborts any in-flight ITR the same cycle.
//  FSM states: RUN, HALTING, HALTED, ISSUE, WAIT_RETIRE, RESUMING.
//   RUN: write DBGSC with bit0=1 -> HALTING. If halted is already 1, go straight to HALTED.
//   HALTING: halt_req=1; leave when halted=1 -> HALTED.
//   HALTED: write ITR3 (its data stored in ITR3 first) -> ISSUE with idx=0.
//           write DRUNCTRL with bit0=1 -> RESUMING.
//   ISSUE: itr_valid=1, itr_insn=ITR[idx]; on itr_valid&itr_ready -> WAIT_RETIRE with timer cleared.
//          itr_insn must remain stable until the handshake.
//   WAIT_RETIRE: timer++ each cycle. On itr_retire: idx==3 -> HALTED with idx=0, else idx++ -> ISSUE.
//     itr_error, or timer reaching ITR_TIMEOUT, sets err, discards remaining ITRs and goes to HALTED with idx=0.
//     If itr_error and itr_retire arrive in the same cycle, the error wins.
//   RESUMING: resume_req=1; leave when halted=0 -> RUN.
//  Illegal accesses set sticky err and leave state and registers unchanged:
//   - ITR3 write outside HALTED;
//   - any ITR0-3 write while busy;
//   - DRUNCTRL resume outside HALTED.
//  DBGSC write bit1=1 clears err. When the same write also sets bit0, the halt request is processed too.
//  Reads, 1-cycle latency, registered:
//   - offsets 0-5 return STATUS {29'b0, err, dbg_busy, halted};
//   - 6 returns DTR[63:32], 7 returns DTR[31:0];
//   - 8-15 return 0.
//   dbg_wr and dbg_rd in the same cycle: the write is performed, and the read returns the pre-write value.
//  DTR: debug writes to 6/7 update their half. dtr_core_wr updates all 64 bits.
//   In a same-cycle collision the debug write wins for its half; the core data updates the other half.
//  Writes to offsets 8-15 are ignored and do not set err.
// TESTING
//  1. Halt, then load ITR0-3 = 0x13,0x93,0x113,0x193 with ready/retire after 1 cycle each.
//     -> itr_idx 0,1,2,3 in order, insn values match, back in HALTED, dbg_busy falls.
//  2. Hold itr_ready=0 for 10 cycles in ISSUE -> itr_valid stays 1 and itr_insn stays stable.
//     Then ready=1 -> single handshake, no duplicate issue.
//  3. Never assert itr_retire -> err=1 after exactly ITR_TIMEOUT cycles, state HALTED, STATUS read = 0x4|halted.
//  4. Write ITR3 while RUN -> no itr_valid, err=1. DBGSC write 0x2 -> err=0.
//  5. Debug write DTR_LO=0xA5A5A5A5 in the same cycle as core write 0x1111_2222_3333_4444.
//     -> DTR = 0x11112222_A5A5A5A5. Reads of offsets 6/7 confirm, 1 cycle later.
//  6. Assert rst during WAIT_RETIRE with idx=2 -> next cycle state RUN, all outputs 0, ITRs and DTR = 0.

Source files
------------

// File: rtl/core_dbg_itr_ctrl.sv
// core_dbg_itr_ctrl
// Debug-interface controller. It holds the DBGSC, DRUNCTRL, ITR0-3 and DTR registers
// at offsets 0-7. It sequences halt, resume and ITR execution, and it injects ITR0..ITR3
// one at a time into the halted core over a valid/ready port. The 64-bit DTR is shared
// between the debug port and the core.
// Register map: 0 DBGSC, 1 DRUNCTRL, 2..5 ITR0..ITR3, 6 DTR_HI, 7 DTR_LO.
module core_dbg_itr_ctrl #(
  parameter int INSN_WIDTH  = 32,
  parameter int DTR_WIDTH   = 64,
  parameter int ITR_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dbg_wr,
  input  logic                  i_dbg_rd,
  input  logic [3:0]            i_dbg_addr,
  input  logic [31:0]           i_dbg_wdata,
  output logic [31:0]           o_dbg_rdata,
  output logic                  o_dbg_busy,
  output logic                  o_halt_req,
  input  logic                  i_halted,
  output logic                  o_resume_req,
  output logic                  o_itr_valid,
  input  logic                  i_itr_ready,
  output logic [INSN_WIDTH-1:0] o_itr_insn,
  output logic [1:0]            o_itr_idx,
  input  logic                  i_itr_retire,
  input  logic                  i_itr_error,
  input  logic                  i_dtr_core_wr,
  input  logic [DTR_WIDTH-1:0]  i_dtr_core_wdata,
  output logic [DTR_WIDTH-1:0]  o_dtr_core_rdata
);

  localparam int HALF_W = DTR_WIDTH / 2;
  localparam int TMR_W  = $clog2(ITR_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ITR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RUN         = 3'd0,
    S_HALTING     = 3'd1,
    S_HALTED      = 3'd2,
    S_ISSUE       = 3'd3,
    S_WAIT_RETIRE = 3'd4,
    S_RESUMING    = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_idx, w_idx_nxt;
  logic [TMR_W-1:0]      r_timer, w_timer_nxt;
  logic                  r_err, w_err_nxt, w_abort;
  logic [INSN_WIDTH-1:0] r_itr [4];
  logic [DTR_WIDTH-1:0]  r_dtr;
  logic [31:0]           r_rdata, w_rd_val, w_status;
  logic                  r_busy, r_halt_req, r_resume_req, r_itr_valid;
  logic [INSN_WIDTH-1:0] r_itr_insn;

  // Write decode and legality checks
  logic        w_wr_dbgsc, w_wr_drun, w_wr_itr, w_busy_st;
  logic        w_itr_bad, w_itr_store, w_run_req, w_run_bad;
  logic        w_wr_dtr_hi, w_wr_dtr_lo;
  logic [3:0]  w_addr_off;
  logic [1:0]  w_itr_sel;
  logic [HALF_W-1:0] w_dtr_hi_nxt, w_dtr_lo_nxt;

  assign w_wr_dbgsc  = i_dbg_wr && (i_dbg_addr == 4'd0);
  assign w_wr_drun   = i_dbg_wr && (i_dbg_addr == 4'd1);
  assign w_wr_itr    = i_dbg_wr && (i_dbg_addr >= 4'd2) && (i_dbg_addr <= 4'd5);
  assign w_wr_dtr_hi = i_dbg_wr && (i_dbg_addr == 4'd6);
  assign w_wr_dtr_lo = i_dbg_wr && (i_dbg_addr == 4'd7);
  assign w_addr_off  = i_dbg_addr - 4'd2;
  assign w_itr_sel   = w_addr_off[1:0];
  assign w_busy_st   = (r_state == S_ISSUE) || (r_state == S_WAIT_RETIRE);
  // ITR3 is the trigger, so it is only legal while halted; no ITR may change mid-sequence
  assign w_itr_bad   = w_wr_itr && (w_busy_st || ((w_itr_sel == 2'd3) && (r_state != S_HALTED)));
  assign w_itr_store = w_wr_itr && !w_itr_bad;
  assign w_run_req   = w_wr_drun && i_dbg_wdata[0];
  assign w_run_bad   = w_run_req && (r_state != S_HALTED);
  assign w_status    = {29'd0, r_err, w_busy_st, i_halted};

  // A debug half-write wins over the core for that half; the core still updates the other half
  assign w_dtr_hi_nxt = w_wr_dtr_hi   ? i_dbg_wdata[HALF_W-1:0] :
                        i_dtr_core_wr ? i_dtr_core_wdata[DTR_WIDTH-1:HALF_W] :
                                        r_dtr[DTR_WIDTH-1:HALF_W];
  assign w_dtr_lo_nxt = w_wr_dtr_lo   ? i_dbg_wdata[HALF_W-1:0] :
                        i_dtr_core_wr ? i_dtr_core_wdata[HALF_W-1:0] :
                                        r_dtr[HALF_W-1:0];

  // Next-state, ITR index and retire timer
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_abort     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_wr_dbgsc && i_dbg_wdata[0]) begin
          w_state_nxt = i_halted ? S_HALTED : S_HALTING;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_HALTING: begin
        if (i_halted) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_HALTING;
        end
      end
      S_HALTED: begin
        if (w_itr_store && (w_itr_sel == 2'd3)) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = 2'd0;
        end else if (w_run_req) begin
          w_state_nxt = S_RESUMING;
        end else begin
          w_state_nxt = S_HALTED;
        end
      end
      S_ISSUE: begin
        if (i_itr_ready) begin
          w_state_nxt = S_WAIT_RETIRE;
          w_timer_nxt = '0;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_RETIRE: begin
        // Error beats retire; a retire in the last allowed cycle still counts
        if (i_itr_error) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HALTED;
          w_idx_nxt   = 2'd0;
        end else if (i_itr_retire) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = S_HALTED;
            w_idx_nxt   = 2'd0;
          end else begin
            w_state_nxt = S_ISSUE;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end else if (r_timer == TMR_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_HALTED;
          w_idx_nxt   = 2'd0;
        end else begin
          w_timer_nxt = r_timer + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      S_RESUMING: begin
        if (!i_halted) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_RESUMING;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // Sticky error: setting events take priority over a DBGSC clear
  always_comb begin
    if (w_abort || w_itr_bad || w_run_bad) begin
      w_err_nxt = 1'b1;
    end else if (w_wr_dbgsc && i_dbg_wdata[1]) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Read data mux; the read sees register contents before any same-cycle write
  always_comb begin
    case (i_dbg_addr)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: w_rd_val = w_status;
      4'd6:    w_rd_val = 32'(r_dtr[DTR_WIDTH-1:HALF_W]);
      4'd7:    w_rd_val = 32'(r_dtr[HALF_W-1:0]);
      default: w_rd_val = 32'd0;
    endcase
  end

  // Control state, index, timer and error registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_idx   <= 2'd0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Register file (ITRs, DTR) and registered read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) r_itr[k] <= '0;
      r_dtr   <= '0;
      r_rdata <= 32'd0;
    end else begin
      if (w_itr_store) r_itr[w_itr_sel] <= i_dbg_wdata[INSN_WIDTH-1:0];
      r_dtr <= {w_dtr_hi_nxt, w_dtr_lo_nxt};
      if (i_dbg_rd) r_rdata <= w_rd_val;
    end
  end

  // Outputs registered from the next state so they line up with the state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy       <= 1'b0;
      r_halt_req   <= 1'b0;
      r_resume_req <= 1'b0;
      r_itr_valid  <= 1'b0;
      r_itr_insn   <= '0;
    end else begin
      r_busy       <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT_RETIRE);
      r_halt_req   <= (w_state_nxt == S_HALTING);
      r_resume_req <= (w_state_nxt == S_RESUMING);
      r_itr_valid  <= (w_state_nxt == S_ISSUE);
      r_itr_insn   <= (w_state_nxt == S_ISSUE) ? r_itr[w_idx_nxt] : '0;
    end
  end

  assign o_dbg_rdata      = r_rdata;
  assign o_dbg_busy       = r_busy;
  assign o_halt_req       = r_halt_req;
  assign o_resume_req     = r_resume_req;
  assign o_itr_valid      = r_itr_valid;
  assign o_itr_insn       = r_itr_insn;
  assign o_itr_idx        = r_idx;
  assign o_dtr_core_rdata = r_dtr;

endmodule

// File: tb/tb_core_dbg_itr_ctrl.sv
// Bench for core_dbg_itr_ctrl: a vector table for register access and halt entry,
// then hand-written sequences for ITR issue, stall, timeout, error, DTR collision and reset.
module tb_core_dbg_itr_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, dbg_wr, dbg_rd, halted, itr_ready, itr_retire, itr_error, dtr_core_wr;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata, itr_insn;
  logic        dbg_busy, halt_req, resume_req, itr_valid;
  logic [1:0]  itr_idx;
  logic [63:0] dtr_core_wdata, dtr_core_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_dbg_itr_ctrl #(.INSN_WIDTH(32), .DTR_WIDTH(64), .ITR_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_dbg_wr(dbg_wr), .i_dbg_rd(dbg_rd),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata),
    .o_dbg_busy(dbg_busy), .o_halt_req(halt_req), .i_halted(halted),
    .o_resume_req(resume_req), .o_itr_valid(itr_valid), .i_itr_ready(itr_ready),
    .o_itr_insn(itr_insn), .o_itr_idx(itr_idx), .i_itr_retire(itr_retire),
    .i_itr_error(itr_error), .i_dtr_core_wr(dtr_core_wr),
    .i_dtr_core_wdata(dtr_core_wdata), .o_dtr_core_rdata(dtr_core_rdata)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        halted;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_hr;
    logic        exp_rr;
    logic        exp_valid;
    logic        exp_busy;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mkv(input logic wr, input logic rd, input logic [3:0] addr,
                               input logic [31:0] wdata, input logic h, input logic chk,
                               input logic [31:0] er, input logic hr, input logic rr,
                               input logic v, input logic b);
    vec_t x;
    x.wr = wr; x.rd = rd; x.addr = addr; x.wdata = wdata; x.halted = h;
    x.chk_rd = chk; x.exp_rdata = er; x.exp_hr = hr; x.exp_rr = rr;
    x.exp_valid = v; x.exp_busy = b;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    dbg_wr = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_wr = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    dbg_rd = 1'b1; dbg_addr = a;
    tick();
    dbg_rd = 1'b0;
    check(name, 64'(dbg_rdata), 64'(exp));
  endtask

  // One ITR handshake followed one cycle later by retire
  task automatic hs_retire();
    itr_ready = 1'b1; tick(); itr_ready = 1'b0;
    itr_retire = 1'b1; tick(); itr_retire = 1'b0;
  endtask

  logic [31:0] ins [4];

  initial begin
    ins[0] = 32'h13; ins[1] = 32'h93; ins[2] = 32'h113; ins[3] = 32'h193;
    //             wr    rd    addr   wdata          h     chk   exp_rdata      hr    rr    v     b
    vt[0]  = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[1]  = mkv(1'b1, 1'b1, 4'd6, 32'hDEADBEEF,  1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[2]  = mkv(1'b0, 1'b1, 4'd6, 32'd0,         1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 1'b0);
    vt[3]  = mkv(1'b1, 1'b0, 4'd7, 32'h01234567,  1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[4]  = mkv(1'b0, 1'b1, 4'd7, 32'd0,         1'b0, 1'b1, 32'h01234567,  1'b0, 1'b0, 1'b0, 1'b0);
    vt[5]  = mkv(1'b0, 1'b1, 4'd9, 32'd0,         1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[6]  = mkv(1'b1, 1'b0, 4'd9, 32'hFFFFFFFF,  1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[7]  = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[8]  = mkv(1'b1, 1'b0, 4'd5, 32'h77,        1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[9]  = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'h4,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[10] = mkv(1'b1, 1'b1, 4'd0, 32'h2,         1'b0, 1'b1, 32'h4,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[11] = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[12] = mkv(1'b1, 1'b0, 4'd1, 32'h1,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[13] = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'h4,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[14] = mkv(1'b1, 1'b1, 4'd0, 32'h3,         1'b0, 1'b1, 32'h4,         1'b1, 1'b0, 1'b0, 1'b0);
    vt[15] = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0);
    vt[16] = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b1, 1'b1, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[17] = mkv(1'b1, 1'b0, 4'd2, 32'h13,        1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[18] = mkv(1'b1, 1'b0, 4'd3, 32'h93,        1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[19] = mkv(1'b1, 1'b0, 4'd4, 32'h113,       1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0);
    vt[20] = mkv(1'b0, 1'b1, 4'd0, 32'd0,         1'b1, 1'b1, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; dbg_wr = 1'b0; dbg_rd = 1'b0; dbg_addr = 4'd0; dbg_wdata = 32'd0;
    halted = 1'b0; itr_ready = 1'b0; itr_retire = 1'b0; itr_error = 1'b0;
    dtr_core_wr = 1'b0; dtr_core_wdata = 64'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst rdata", 64'(dbg_rdata), 64'd0);
    check("rst busy", 64'(dbg_busy), 64'd0);
    check("rst halt_req", 64'(halt_req), 64'd0);
    check("rst valid", 64'(itr_valid), 64'd0);
    check("rst dtr", dtr_core_rdata, 64'd0);

    // Table: register access, illegal writes, err clear, halt entry, ITR0-2 load
    for (int i = 0; i < 21; i++) begin
      dbg_wr = vt[i].wr; dbg_rd = vt[i].rd; dbg_addr = vt[i].addr;
      dbg_wdata = vt[i].wdata; halted = vt[i].halted;
      tick();
      dbg_wr = 1'b0; dbg_rd = 1'b0;
      if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), 64'(dbg_rdata), 64'(vt[i].exp_rdata));
      check($sformatf("vec%0d halt_req", i), 64'(halt_req), 64'(vt[i].exp_hr));
      check($sformatf("vec%0d resume_req", i), 64'(resume_req), 64'(vt[i].exp_rr));
      check($sformatf("vec%0d itr_valid", i), 64'(itr_valid), 64'(vt[i].exp_valid));
      check($sformatf("vec%0d busy", i), 64'(dbg_busy), 64'(vt[i].exp_busy));
    end

    // ITR0-3 issued in order
    wr_reg(4'd5, 32'h193);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1 valid%0d", k), 64'(itr_valid), 64'd1);
      check($sformatf("t1 idx%0d", k), 64'(itr_idx), 64'(k));
      check($sformatf("t1 insn%0d", k), 64'(itr_insn), 64'(ins[k]));
      check($sformatf("t1 busy%0d", k), 64'(dbg_busy), 64'd1);
      tick();
      check($sformatf("t1 hold%0d", k), 64'(itr_valid), 64'd1);
      itr_ready = 1'b1; tick(); itr_ready = 1'b0;
      check($sformatf("t1 wait valid%0d", k), 64'(itr_valid), 64'd0);
      check($sformatf("t1 wait busy%0d", k), 64'(dbg_busy), 64'd1);
      itr_retire = 1'b1; tick(); itr_retire = 1'b0;
    end
    check("t1 end valid", 64'(itr_valid), 64'd0);
    check("t1 end busy", 64'(dbg_busy), 64'd0);
    check("t1 end idx", 64'(itr_idx), 64'd0);
    rd_check(4'd0, 32'h1, "t1 status");

    // Stall in ISSUE, then single handshake, then timeout
    wr_reg(4'd5, 32'h193);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t2 valid c%0d", c), 64'(itr_valid), 64'd1);
      check($sformatf("t2 insn c%0d", c), 64'(itr_insn), 64'h13);
      tick();
    end
    itr_ready = 1'b1; tick(); itr_ready = 1'b0;
    check("t2 no dup valid", 64'(itr_valid), 64'd0);
    repeat (T - 2) tick();
    check("t3 busy before timeout", 64'(dbg_busy), 64'd1);
    dbg_rd = 1'b1; dbg_addr = 4'd0; tick();
    check("t3 status T-1", 64'(dbg_rdata), 64'h3);
    check("t3 busy T-1", 64'(dbg_busy), 64'd1);
    tick(); dbg_rd = 1'b0;
    check("t3 status T", 64'(dbg_rdata), 64'h3);
    check("t3 busy T", 64'(dbg_busy), 64'd0);
    check("t3 idx T", 64'(itr_idx), 64'd0);
    rd_check(4'd0, 32'h5, "t3 status err");
    wr_reg(4'd0, 32'h2);
    rd_check(4'd0, 32'h1, "t3 err cleared");

    // Error and retire in the same cycle: error wins
    wr_reg(4'd5, 32'h193);
    itr_ready = 1'b1; tick(); itr_ready = 1'b0;
    itr_retire = 1'b1; itr_error = 1'b1; tick(); itr_retire = 1'b0; itr_error = 1'b0;
    check("err valid", 64'(itr_valid), 64'd0);
    check("err busy", 64'(dbg_busy), 64'd0);
    check("err idx", 64'(itr_idx), 64'd0);
    rd_check(4'd0, 32'h5, "err status");
    wr_reg(4'd0, 32'h2);

    // Resume, then halt again
    wr_reg(4'd1, 32'h1);
    check("res rr1", 64'(resume_req), 64'd1);
    tick();
    check("res rr2", 64'(resume_req), 64'd1);
    halted = 1'b0; tick();
    check("res done", 64'(resume_req), 64'd0);
    rd_check(4'd0, 32'h0, "res status");
    wr_reg(4'd0, 32'h1);
    check("rehalt hr", 64'(halt_req), 64'd1);
    halted = 1'b1; tick();
    check("rehalt hr off", 64'(halt_req), 64'd0);

    // DTR collisions
    dbg_wr = 1'b1; dbg_addr = 4'd7; dbg_wdata = 32'hA5A5A5A5;
    dtr_core_wr = 1'b1; dtr_core_wdata = 64'h1111_2222_3333_4444;
    tick(); dbg_wr = 1'b0; dtr_core_wr = 1'b0;
    check("t5 dtr", dtr_core_rdata, 64'h11112222_A5A5A5A5);
    rd_check(4'd6, 32'h11112222, "t5 rd hi");
    rd_check(4'd7, 32'hA5A5A5A5, "t5 rd lo");
    dbg_wr = 1'b1; dbg_addr = 4'd6; dbg_wdata = 32'hCAFEF00D;
    dtr_core_wr = 1'b1; dtr_core_wdata = 64'h5555_6666_7777_8888;
    tick(); dbg_wr = 1'b0; dtr_core_wr = 1'b0;
    check("t5 dtr hi win", dtr_core_rdata, 64'hCAFEF00D_77778888);
    dtr_core_wr = 1'b1; dtr_core_wdata = 64'h0123_4567_89AB_CDEF;
    tick(); dtr_core_wr = 1'b0;
    check("t5 core only", dtr_core_rdata, 64'h01234567_89ABCDEF);

    // Reset in WAIT_RETIRE with idx 2
    wr_reg(4'd5, 32'h193);
    hs_retire();
    hs_retire();
    itr_ready = 1'b1; tick(); itr_ready = 1'b0;
    check("t6 idx2", 64'(itr_idx), 64'd2);
    check("t6 busy", 64'(dbg_busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6 rdata", 64'(dbg_rdata), 64'd0);
    check("t6 busy0", 64'(dbg_busy), 64'd0);
    check("t6 hr", 64'(halt_req), 64'd0);
    check("t6 rr", 64'(resume_req), 64'd0);
    check("t6 valid", 64'(itr_valid), 64'd0);
    check("t6 insn", 64'(itr_insn), 64'd0);
    check("t6 idx", 64'(itr_idx), 64'd0);
    check("t6 dtr", dtr_core_rdata, 64'd0);
    // Core already halted: straight to HALTED without a halt request
    wr_reg(4'd0, 32'h1);
    check("t6 fast halt hr", 64'(halt_req), 64'd0);
    rd_check(4'd0, 32'h1, "t6 status");
    rd_check(4'd6, 32'h0, "t6 dtr hi");
    wr_reg(4'd5, 32'h0);
    check("t6 reissue valid", 64'(itr_valid), 64'd1);
    check("t6 itr0 cleared", 64'(itr_insn), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
